// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - raster pixel stream to 3x3 interior window generator
//
// Ports:
//    clk, rst_n   clock (rising edge) and asynchronous active-low reset
//    pix_in       input pixel, SIZE bits
//    pix_valid    pix_in accepted on this edge (no backpressure)
//    sof          start of frame, qualified by pix_valid, marks pixel (0,0)
//    win_out      packed 3x3 window, element (r,c) at [(3r+c)*SIZE +: SIZE]
//    win_valid    win_out holds a new interior window this cycle
//    frame_done   one-cycle pulse after the last pixel of a frame
//    frame_err    one-cycle pulse when sof arrives mid-frame
//    win_last     (WIN_LAST_FLAG_EN only) marks the final window of a frame
//
// Optional feature macro: WIN_LAST_FLAG_EN

module window_3x3_gen #(
   parameter int SIZE  = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SIZE-1:0]   pix_in,
   input  logic              pix_valid,
   input  logic              sof,
   output logic [9*SIZE-1:0] win_out,
   output logic              win_valid,
   output logic              frame_done,
`ifdef WIN_LAST_FLAG_EN
   output logic              win_last,
`endif
   output logic              frame_err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [9*SIZE-1:0]   win_q, win_d;
   logic                win_valid_q, win_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                frame_err_q, frame_err_d;
`ifdef WIN_LAST_FLAG_EN
   logic                win_last_q, win_last_d;
`endif

   // lb0 holds the line two rows up, lb1 the line one row up
   logic [SIZE-1:0]     lb0_mem [0:IMG_W-1];
   logic [SIZE-1:0]     lb1_mem [0:IMG_W-1];

   logic                accept;
   logic                restart;
   logic                at_last;
   logic [CW-1:0]       col_cur;
   logic [RW-1:0]       row_cur;
   logic [SIZE-1:0]     lb0_rd;
   logic [SIZE-1:0]     lb1_rd;

   always_comb begin
      restart = pix_valid & sof;
      accept  = pix_valid & (sof | (state_q == ACTIVE));
      // a sof pixel is always (0,0), whatever position the counters hold
      col_cur = restart ? '0 : col_q;
      row_cur = restart ? '0 : row_q;
      lb0_rd  = lb0_mem[col_cur];
      lb1_rd  = lb1_mem[col_cur];
      at_last = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = restart && (state_q == ACTIVE);
`ifdef WIN_LAST_FLAG_EN
      win_last_d   = 1'b0;
`endif

      if (accept) begin
         state_d = ACTIVE;
         for (int r = 0; r < 3; r++) begin
            win_d[(3*r)*SIZE   +: SIZE] = win_q[(3*r+1)*SIZE +: SIZE];
            win_d[(3*r+1)*SIZE +: SIZE] = win_q[(3*r+2)*SIZE +: SIZE];
         end
         win_d[2*SIZE +: SIZE] = lb0_rd;
         win_d[5*SIZE +: SIZE] = lb1_rd;
         win_d[8*SIZE +: SIZE] = pix_in;

         if (col_cur == COL_LAST) begin
            col_d = '0;
            if (row_cur == ROW_LAST) begin
               row_d   = '0;
               state_d = IDLE;
            end else begin
               row_d = row_cur + RW'(1);
            end
         end else begin
            col_d = col_cur + CW'(1);
            row_d = row_cur;
         end

         // rows 0/1 of the window hold stale line-buffer data until row 2
         win_valid_d  = (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
         frame_done_d = at_last;
`ifdef WIN_LAST_FLAG_EN
         win_last_d   = at_last;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef WIN_LAST_FLAG_EN
         win_last_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
`ifdef WIN_LAST_FLAG_EN
         win_last_q   <= win_last_d;
`endif
      end
   end

   // line buffers are plain storage; the row gate keeps their power-up
   // contents from ever reaching win_valid
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_mem[col_cur] <= lb1_rd;
         lb1_mem[col_cur] <= pix_in;
      end
   end

   assign win_out    = win_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
`ifdef WIN_LAST_FLAG_EN
   assign win_last   = win_last_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - scoreboard bench for window_3x3_gen (5x4 frames)

module tb_window_3x3_gen;

   localparam int SIZE  = 8;
   localparam int IMG_W = 5;
   localparam int IMG_H = 4;

   logic              clk;
   logic              rst_n;
   logic [SIZE-1:0]   pix_in;
   logic              pix_valid;
   logic              sof;
   logic [9*SIZE-1:0] win_out;
   logic              win_valid;
   logic              frame_done;
   logic              frame_err;
`ifdef WIN_LAST_FLAG_EN
   logic              win_last;
`endif

   window_3x3_gen #(.SIZE(SIZE), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .sof        (sof),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .frame_done (frame_done),
`ifdef WIN_LAST_FLAG_EN
      .win_last   (win_last),
`endif
      .frame_err  (frame_err)
   );

   typedef struct packed {
      logic [71:0] win;
      logic        last;
   } exp_t;

   exp_t q[$];
   int   cmp_cnt  = 0;
   int   err_cnt  = 0;
   int   win_cnt  = 0;
   int   done_cnt = 0;
   int   ferr_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      cmp_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // window whose bottom-right pixel is (r,c), with pixel value row*16+col
   function automatic logic [71:0] exp_win(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(3*i+j)*8 +: 8] = 8'((r - 2 + i) * 16 + (c - 2 + j));
      return w;
   endfunction

   // monitor: pops one expectation per presented window
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (win_valid) begin
            win_cnt++;
            if (q.size() == 0) begin
               cmp_cnt++;
               err_cnt++;
               $display("FAIL unexpected_window: got %h expected no window", win_out);
            end else begin
               e = q.pop_front();
               chk("window", win_out, e.win);
`ifdef WIN_LAST_FLAG_EN
               chki("win_last", int'(win_last), int'(e.last));
`endif
            end
         end
`ifdef WIN_LAST_FLAG_EN
         else begin
            chki("win_last_idle", int'(win_last), 0);
         end
`endif
         if (frame_done) done_cnt++;
         if (frame_err)  ferr_cnt++;
      end
   end

   task automatic drive(input int r, input int c, input bit s, input bit ex);
      exp_t e;
      pix_in    = 8'(r * 16 + c);
      sof       = s;
      pix_valid = 1'b1;
      if (ex && r >= 2 && c >= 2) begin
         e.win  = exp_win(r, c);
         e.last = (r == IMG_H - 1) && (c == IMG_W - 1);
         q.push_back(e);
      end
   endtask

   task automatic send_pix(input int r, input int c, input bit s, input bit ex);
      @(negedge clk);
      drive(r, c, s, ex);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pix_valid = 1'b0;
         sof       = 1'b0;
      end
   endtask

   // full frame; gap inserts one idle cycle after each pixel
   task automatic send_frame(input bit gap, input bit hand, input int exp_err);
      logic [71:0] snap;
      @(negedge clk);
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            drive(r, c, (r == 0 && c == 0), 1'b1);
            @(negedge clk);
            if (r == 0 && c == 0)
               chki("frame_err_pulse", int'(frame_err), exp_err);
            if (hand && r == 2 && c == 2) begin
               chk("first_window", win_out, 72'h222120121110020100);
               chki("first_centre", int'(win_out[39:32]), 'h11);
            end
            if (r == IMG_H - 1 && c == IMG_W - 1) begin
               chki("frame_done_timing", int'(frame_done), 1);
               chki("last_centre", int'(win_out[39:32]), 'h23);
               pix_valid = 1'b0;
               sof       = 1'b0;
            end
            if (gap) begin
               snap      = win_out;
               pix_valid = 1'b0;
               sof       = 1'b0;
               @(negedge clk);
               chk("gap_hold", win_out, snap);
               chki("gap_valid", int'(win_valid), 0);
            end
         end
      end
      pix_valid = 1'b0;
      sof       = 1'b0;
   endtask

   task automatic check_counts(input string tag, input int w0, input int d0, input int e0,
                               input int wn, input int dn, input int en);
      idle(3);
      chki({tag, "_windows"}, win_cnt - w0, wn);
      chki({tag, "_frame_done"}, done_cnt - d0, dn);
      chki({tag, "_frame_err"}, ferr_cnt - e0, en);
      chki({tag, "_queue_empty"}, q.size(), 0);
   endtask

   initial begin
      int w0, d0, e0;
      rst_n     = 1'b0;
      pix_in    = '0;
      pix_valid = 1'b0;
      sof       = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_win_out", win_out, 72'h0);
      chki("reset_win_valid", int'(win_valid), 0);
      chki("reset_frame_done", int'(frame_done), 0);
      chki("reset_frame_err", int'(frame_err), 0);
      rst_n = 1'b1;

      // pixels without sof after reset are dropped
      w0 = win_cnt; d0 = done_cnt; e0 = ferr_cnt;
      for (int i = 0; i < 2 * IMG_H * IMG_W; i++)
         send_pix((i / IMG_W) % IMG_H, i % IMG_W, 1'b0, 1'b0);
      check_counts("no_sof", w0, d0, e0, 0, 0, 0);

      // continuous frame
      w0 = win_cnt; d0 = done_cnt; e0 = ferr_cnt;
      send_frame(1'b0, 1'b1, 0);
      check_counts("continuous", w0, d0, e0, 6, 1, 0);

      // alternating pix_valid
      w0 = win_cnt; d0 = done_cnt; e0 = ferr_cnt;
      send_frame(1'b1, 1'b0, 0);
      check_counts("gapped", w0, d0, e0, 6, 1, 0);

      // sof reasserted at (2,1): frame restarts
      w0 = win_cnt; d0 = done_cnt; e0 = ferr_cnt;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < IMG_W; c++)
            send_pix(r, c, (r == 0 && c == 0), 1'b0);
      send_pix(2, 0, 1'b0, 1'b0);
      send_frame(1'b0, 1'b0, 1);
      check_counts("restart", w0, d0, e0, 6, 1, 1);

      // asynchronous reset mid-frame at (2,3)
      w0 = win_cnt; d0 = done_cnt; e0 = ferr_cnt;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < IMG_W && !(r == 2 && c == 3); c++)
            send_pix(r, c, (r == 0 && c == 0), 1'b1);
      @(negedge clk);
      pix_valid = 1'b0;
      chki("pre_reset_valid", int'(win_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chki("reset_drop_valid", int'(win_valid), 0);
      chk("reset_drop_win_out", win_out, 72'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check_counts("reset_partial", w0, d0, e0, 1, 0, 0);

      w0 = win_cnt; d0 = done_cnt; e0 = ferr_cnt;
      send_frame(1'b0, 1'b1, 0);
      check_counts("after_reset", w0, d0, e0, 6, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
